// File: rtl/trace_buffer.sv
// Instruction trace buffer: captures retired {pc, inst, addr} into a circular
// store under arm/trigger/stop control and lets the host pop entries oldest-first.
module trace_buffer #(
    parameter int DEPTH = 16,
    parameter int WRAP  = 0
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     clear,
    input  logic                     trig_en,
    input  logic [31:0]              trig_pc,
    input  logic                     cap_valid,
    input  logic [31:0]              cap_pc,
    input  logic [31:0]              cap_inst,
    input  logic [63:0]              cap_addr,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [31:0]              rd_pc,
    output logic [31:0]              rd_inst,
    output logic [63:0]              rd_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic [1:0]               state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_CAPT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            rd_valid_q;
    logic [31:0]     rd_pc_q, rd_inst_q;
    logic [63:0]     rd_addr_q;

    logic [31:0]     mem_pc   [DEPTH];
    logic [31:0]     mem_inst [DEPTH];
    logic [63:0]     mem_addr [DEPTH];

    logic            trig_hit;
    logic            wr_req;
    logic            wr_go;
    logic            wr_drop;
    logic            wr_ovr;
    logic            pop_go;
    logic            pop_fire;
    logic            is_full;

    always_comb begin
        is_full  = (count_q == CW'(DEPTH));
        pop_go   = rd_en && (count_q != '0);
        // A matching PC while armed both triggers and is itself the first entry.
        trig_hit = (state_q == S_ARMED) && cap_valid && (cap_pc == trig_pc) && !stop;
        wr_req   = cap_valid && ((state_q == S_CAPT) || trig_hit);
        // A simultaneous pop frees a slot, so a full buffer neither drops nor overwrites.
        wr_drop  = wr_req && is_full && !pop_go && (WRAP == 0);
        wr_ovr   = wr_req && is_full && !pop_go && (WRAP != 0);
        wr_go    = wr_req && !wr_drop;
        pop_fire = pop_go && !clear;
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q | wr_drop | wr_ovr;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) state_d = trig_en ? S_ARMED : S_CAPT;
            end
            S_ARMED: begin
                if (stop)          state_d = S_DONE;
                else if (trig_hit) state_d = wr_drop ? S_DONE : S_CAPT;
            end
            S_CAPT: begin
                if (stop || wr_drop) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_go)            wptr_d = wptr_q + AW'(1);
        if (pop_go || wr_ovr) rptr_d = rptr_q + AW'(1);

        case ({wr_go && !wr_ovr, pop_go})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (clear) begin
            state_d = S_IDLE;
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_pc_q    <= '0;
            rd_inst_q  <= '0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= pop_fire;
            if (pop_fire) begin
                rd_pc_q   <= mem_pc[rptr_q];
                rd_inst_q <= mem_inst[rptr_q];
                rd_addr_q <= mem_addr[rptr_q];
            end
        end
    end

    // Storage array carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_go) begin
            mem_pc[wptr_q]   <= cap_pc;
            mem_inst[wptr_q] <= cap_inst;
            mem_addr[wptr_q] <= cap_addr;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_pc    = rd_pc_q;
    assign rd_inst  = rd_inst_q;
    assign rd_addr  = rd_addr_q;
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = is_full;
    assign overflow = ovf_q;
    assign state    = state_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: a stop-when-full and a wrapping instance
// share stimulus and are checked against hand-computed values.
module tb_trace_buffer;

    logic        clk = 1'b0;
    logic        aresetn, arm, stop, clear, trig_en, cap_valid, rd_en;
    logic [31:0] trig_pc, cap_pc, cap_inst;
    logic [63:0] cap_addr;

    logic        rd_valid0, empty0, full0, ovf0;
    logic [31:0] rd_pc0, rd_inst0;
    logic [63:0] rd_addr0;
    logic [4:0]  count0;
    logic [1:0]  state0;

    logic        rd_valid1, empty1, full1, ovf1;
    logic [31:0] rd_pc1, rd_inst1;
    logic [63:0] rd_addr1;
    logic [4:0]  count1;
    logic [1:0]  state1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    trace_buffer #(.DEPTH(16), .WRAP(0)) u_dut0 (
        .clk(clk), .aresetn(aresetn), .arm(arm), .stop(stop), .clear(clear),
        .trig_en(trig_en), .trig_pc(trig_pc), .cap_valid(cap_valid),
        .cap_pc(cap_pc), .cap_inst(cap_inst), .cap_addr(cap_addr), .rd_en(rd_en),
        .rd_valid(rd_valid0), .rd_pc(rd_pc0), .rd_inst(rd_inst0), .rd_addr(rd_addr0),
        .count(count0), .empty(empty0), .full(full0), .overflow(ovf0), .state(state0)
    );

    trace_buffer #(.DEPTH(16), .WRAP(1)) u_dut1 (
        .clk(clk), .aresetn(aresetn), .arm(arm), .stop(stop), .clear(clear),
        .trig_en(trig_en), .trig_pc(trig_pc), .cap_valid(cap_valid),
        .cap_pc(cap_pc), .cap_inst(cap_inst), .cap_addr(cap_addr), .rd_en(rd_en),
        .rd_valid(rd_valid1), .rd_pc(rd_pc1), .rd_inst(rd_inst1), .rd_addr(rd_addr1),
        .count(count1), .empty(empty1), .full(full1), .overflow(ovf1), .state(state1)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [31:0] pc);
        cap_valid = 1'b1;
        cap_pc    = pc;
        cap_inst  = ~pc;
        cap_addr  = {32'hA5A5_0000, pc};
        tick();
        cap_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_arm(input logic te);
        trig_en = te;
        arm     = 1'b1;
        tick();
        arm     = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0; arm = 1'b0; stop = 1'b0; clear = 1'b0; trig_en = 1'b0;
        cap_valid = 1'b0; rd_en = 1'b0; trig_pc = '0; cap_pc = '0;
        cap_inst = '0; cap_addr = '0;
        tick();
        tick();
        chk("rst_state",    64'(state0), 64'd0);
        chk("rst_count",    64'(count0), 64'd0);
        chk("rst_empty",    64'(empty0), 64'd1);
        chk("rst_full",     64'(full0), 64'd0);
        chk("rst_ovf",      64'(ovf1), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid0), 64'd0);
        chk("rst_rd_pc",    64'(rd_pc0), 64'd0);
        chk("rst_rd_addr",  rd_addr1, 64'd0);
        aresetn = 1'b1;
        tick();

        // Untriggered capture of three entries, then three back-to-back pops.
        do_arm(1'b0);
        chk("s1_state_capt", 64'(state0), 64'd2);
        for (int i = 0; i < 3; i++) cap(32'(4 * i));
        chk("s1_count0", 64'(count0), 64'd3);
        chk("s1_count1", 64'(count1), 64'd3);
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s1_rd_valid", 64'(rd_valid0), 64'd1);
            chk("s1_rd_pc",    64'(rd_pc0), 64'(4 * i));
            if (i == 0) begin
                chk("s1_rd_inst", 64'(rd_inst0), 64'hFFFF_FFFF);
                chk("s1_rd_addr", rd_addr0, 64'hA5A5_0000_0000_0000);
            end
        end
        rd_en = 1'b0;
        chk("s1_empty", 64'(empty0), 64'd1);
        tick();
        chk("s1_no_valid", 64'(rd_valid0), 64'd0);
        chk("s1_hold_pc",  64'(rd_pc0), 64'h8);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("s1_pop_empty", 64'(rd_valid1), 64'd0);
        pulse_clear();
        chk("s1_clear_state", 64'(state0), 64'd0);

        // Triggered capture: only pc 0x10 onward is recorded.
        trig_pc = 32'h10;
        do_arm(1'b1);
        chk("s2_state_armed", 64'(state0), 64'd1);
        cap(32'h0);
        cap(32'h8);
        chk("s2_still_armed", 64'(state1), 64'd1);
        chk("s2_count_zero",  64'(count1), 64'd0);
        cap(32'h10);
        chk("s2_state_capt", 64'(state0), 64'd2);
        cap(32'h14);
        chk("s2_count", 64'(count0), 64'd2);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("s2_first_pc", 64'(rd_pc0), 64'h10);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("s2_state_done", 64'(state1), 64'd3);
        pulse_clear();

        // 20 captures: instance 0 stops at 16, instance 1 keeps the newest 16.
        do_arm(1'b0);
        for (int i = 0; i < 20; i++) cap(32'(i));
        chk("s3_full0",   64'(full0), 64'd1);
        chk("s3_ovf0",    64'(ovf0), 64'd1);
        chk("s3_state0",  64'(state0), 64'd3);
        chk("s3_count0",  64'(count0), 64'd16);
        chk("s3_count1",  64'(count1), 64'd16);
        chk("s3_ovf1",    64'(ovf1), 64'd1);
        chk("s3_state1",  64'(state1), 64'd2);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("s3_pop_pc0", 64'(rd_pc0), 64'(i));
            chk("s3_pop_pc1", 64'(rd_pc1), 64'(i + 4));
        end
        rd_en = 1'b0;
        chk("s3_empty0", 64'(empty0), 64'd1);
        chk("s3_empty1", 64'(empty1), 64'd1);
        pulse_clear();

        // Full buffer with write and pop together: no drop, no overwrite.
        do_arm(1'b0);
        for (int i = 0; i < 16; i++) cap(32'h100 + 32'(i));
        chk("s4_full", 64'(full1), 64'd1);
        rd_en = 1'b1;
        cap(32'h200);
        chk("s4_count0",  64'(count0), 64'd16);
        chk("s4_count1",  64'(count1), 64'd16);
        chk("s4_ovf0",    64'(ovf0), 64'd0);
        chk("s4_ovf1",    64'(ovf1), 64'd0);
        chk("s4_rd_pc",   64'(rd_pc0), 64'h100);
        chk("s4_state0",  64'(state0), 64'd2);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("s4_pop_pc0", 64'(rd_pc0), (i == 16) ? 64'h200 : 64'(32'h100 + 32'(i)));
            chk("s4_pop_pc1", 64'(rd_pc1), (i == 16) ? 64'h200 : 64'(32'h100 + 32'(i)));
        end
        rd_en = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("s4_stop_done", 64'(state0), 64'd3);

        // Clear mid-capture with a pop in the same cycle.
        pulse_clear();
        do_arm(1'b0);
        for (int i = 0; i < 5; i++) cap(32'h40 + 32'(i));
        chk("s5_count5", 64'(count0), 64'd5);
        clear = 1'b1;
        rd_en = 1'b1;
        tick();
        clear = 1'b0;
        rd_en = 1'b0;
        chk("s5_clr_count", 64'(count0), 64'd0);
        chk("s5_clr_empty", 64'(empty1), 64'd1);
        chk("s5_clr_state", 64'(state0), 64'd0);
        chk("s5_clr_ovf",   64'(ovf0), 64'd0);
        chk("s5_clr_valid", 64'(rd_valid0), 64'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("s5_clr_no_pop", 64'(rd_valid1), 64'd0);

        // Reset mid-capture after overflow has been raised.
        do_arm(1'b0);
        for (int i = 0; i < 20; i++) cap(32'(i));
        chk("s6_ovf_set", 64'(ovf1), 64'd1);
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        chk("s6_rst_count", 64'(count1), 64'd0);
        chk("s6_rst_empty", 64'(empty0), 64'd1);
        chk("s6_rst_state", 64'(state1), 64'd0);
        chk("s6_rst_ovf0",  64'(ovf0), 64'd0);
        chk("s6_rst_ovf1",  64'(ovf1), 64'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("s6_rst_no_pop", 64'(rd_valid0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
